sipo_deser: RTL

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_pkg.sv | 16 +
 rtl/sipo_shift_core.sv | 41 ++++
 rtl/sipo_deser.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out deserializer.
// Holds the frame FSM state encoding used by sipo_deser and visible on its debug port.
package sipo_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } sipo_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_SHIFT_LEFT = 1;
  localparam int MIN_DATA_WIDTH     = 2;
  localparam int MAX_DATA_WIDTH     = 64;

endpackage

// File: rtl/sipo_shift_core.sv
// Working shift register of the deserializer, direction chosen by SHIFT_LEFT.
// next_o is the value the register takes on the coming edge, so a completed word can be captured on that same edge.
module sipo_shift_core #(
  parameter int WIDTH      = 8,
  parameter int SHIFT_LEFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (clr) begin
      shift_d = '0;
    end else if (en) begin
      if (SHIFT_LEFT != 0) begin
        shift_d = {shift_q[WIDTH-2:0], bit_in};
      end else begin
        shift_d = {bit_in, shift_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign next_o = shift_d;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with valid/ready output and sticky overflow.
// Optional even-parity trailer bit per frame: define SIPO_DESER_PARITY_EN.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SHIFT_LEFT = DEFAULT_SHIFT_LEFT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                serial_in,
  input  logic                                we,
  input  logic                                clear,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(DATA_WIDTH+1)-1:0]     bit_count,
  output logic                                overflow,
  output logic                                parity_err,
  output sipo_state_e                         state_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);

  if (DATA_WIDTH < MIN_DATA_WIDTH || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_width_check
    $error("sipo_deser: DATA_WIDTH out of range");
  end

  sipo_state_e           state_q;
  logic [CW-1:0]         bit_count_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  overflow_q;

  logic                  bit_acc;
  logic                  shift_en;
  logic                  data_last;
  logic                  frame_done;
  logic                  handshake;
  logic                  can_load;
  logic [DATA_WIDTH-1:0] word_d;

  sipo_shift_core #(
    .WIDTH      (DATA_WIDTH),
    .SHIFT_LEFT (SHIFT_LEFT)
  ) u_shift_core (
    .clk    (clk),
    .rst    (rst),
    .en     (shift_en),
    .clr    (clear),
    .bit_in (serial_in),
    .next_o (word_d)
  );

  // Output handshake: a word transfers on any rising edge where out_valid=1 and
  // out_ready=1. out_data is frozen while out_valid=1 and out_ready=0; a frame
  // finishing in that window is discarded and raises overflow.
  always_comb begin
    bit_acc   = we & ~clear;
    shift_en  = bit_acc & (state_q != S_PARITY);
    data_last = shift_en & (bit_count_q == LAST_DATA);
    handshake = out_valid_q & out_ready;
    can_load  = ~out_valid_q | out_ready;
`ifdef SIPO_DESER_PARITY_EN
    frame_done = bit_acc & (state_q == S_PARITY);
`else
    frame_done = data_last;
`endif
  end

`ifdef SIPO_DESER_PARITY_EN
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);
  logic parity_err_q;
  logic perr_d;

  // The register is frozen in S_PARITY, so word_d is exactly the data bits.
  assign perr_d = (^word_d) ^ serial_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_count_q  <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (clear) begin
        state_q     <= S_IDLE;
        bit_count_q <= '0;
      end else if (we) begin
        case (state_q)
          S_IDLE: begin
            state_q     <= S_SHIFT;
            bit_count_q <= CW'(1);
          end
          S_SHIFT: begin
            if (data_last) begin
`ifdef SIPO_DESER_PARITY_EN
              state_q     <= S_PARITY;
              bit_count_q <= FULL_CNT;
`else
              state_q     <= S_IDLE;
              bit_count_q <= '0;
`endif
            end else begin
              bit_count_q <= bit_count_q + CW'(1);
            end
          end
          S_PARITY: begin
            state_q     <= S_IDLE;
            bit_count_q <= '0;
          end
          default: begin
            state_q     <= S_IDLE;
            bit_count_q <= '0;
          end
        endcase
      end

      if (frame_done && can_load) begin
        out_data_q   <= word_d;
        out_valid_q  <= 1'b1;
`ifdef SIPO_DESER_PARITY_EN
        parity_err_q <= perr_d;
`endif
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end

      if (clear) begin
        overflow_q <= 1'b0;
      end else if (frame_done && !can_load) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign bit_count = bit_count_q;
  assign overflow  = overflow_q;
  assign state_o   = state_q;
`ifdef SIPO_DESER_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
